// File: rtl/wb_faultmem.sv
// wb_faultmem: pipelined Wishbone memory model with fault injection.
// Out-of-window requests return a bus error. After an error, responses are
// withheld and writes dropped until the master lowers cyc. A rotating stall
// pattern throttles acceptance. Pending and error counters are exposed for
// checking the master's behaviour.
module wb_faultmem #(
   parameter int DW      = 32,
   parameter int AW      = 30,
   parameter int LGMEMSZ = 15,
   parameter int BASE    = 1,
   parameter int LATENCY = 1
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   input  logic            i_wb_we,
   input  logic [AW-1:0]   i_wb_addr,
   input  logic [DW-1:0]   i_wb_data,
   input  logic [DW/8-1:0] i_wb_sel,
   output logic            o_wb_stall,
   output logic            o_wb_ack,
   output logic            o_wb_err,
   output logic [DW-1:0]   o_wb_data,
   input  logic [7:0]      i_stall_pattern,
   output logic [2:0]      o_pending,
   output logic [15:0]     o_err_count
);

   localparam int SW     = DW / 8;
   localparam int MW     = LGMEMSZ - $clog2(SW);
   localparam int NWORDS = 1 << MW;
   localparam logic [AW-MW-1:0] BASE_IDX = BASE[AW-MW-1:0];

   typedef enum logic [1:0] {StIdle, StActive, StFault} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [7:0]        r_pat;
   logic [2:0]        r_pending;
   logic [15:0]       r_err_count;
   logic [DW-1:0]     r_mem [NWORDS];

   // Response pipeline; the last stage is what the bus sees.
   logic              r_vld  [LATENCY];
   logic              r_perr [LATENCY];
   logic [DW-1:0]     r_dat  [LATENCY];

   logic              w_accept;
   logic              w_inwin;
   logic [MW-1:0]     w_idx;
   logic              w_slot_vld;
   logic              w_fault_wr;

   assign w_inwin    = (i_wb_addr[AW-1:MW] == BASE_IDX);
   assign w_idx      = i_wb_addr[MW-1:0];
   assign o_wb_stall = i_wb_cyc && r_pat[0];
   assign w_accept   = i_wb_cyc && i_wb_stb && !o_wb_stall;
   assign w_slot_vld = r_vld[LATENCY-1];

   // Responses are gated by cyc directly so nothing leaks out once the master drops it.
   assign o_wb_ack  = i_wb_cyc && w_slot_vld && !r_perr[LATENCY-1] && (r_state != StFault);
   assign o_wb_err  = i_wb_cyc && w_slot_vld && r_perr[LATENCY-1] && (r_state != StFault);
   assign o_wb_data = r_dat[LATENCY-1];

   assign o_pending   = r_pending;
   assign o_err_count = r_err_count;

   // The error cycle itself already counts as faulted for write suppression.
   assign w_fault_wr = (r_state == StFault) || o_wb_err;

   // State register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state: fault latches on an emitted error and clears when cyc falls.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:   if (i_wb_cyc) w_state_next = StActive;
         StActive: begin
            if (!i_wb_cyc)     w_state_next = StIdle;
            else if (o_wb_err) w_state_next = StFault;
         end
         StFault:  if (!i_wb_cyc) w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   // Stall pattern: load while idle, rotate right while cyc is held.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pat <= 8'h00;
      end else if (!i_wb_cyc) begin
         r_pat <= i_stall_pattern;
      end else begin
         r_pat <= {r_pat[0], r_pat[7:1]};
      end
   end

   // Memory array, byte-lane writes; contents are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (w_accept && i_wb_we && w_inwin && !w_fault_wr) begin
         for (int b = 0; b < SW; b++) begin
            if (i_wb_sel[b]) r_mem[w_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
         end
      end
   end

   // Response pipeline: capture on accept, shift each cycle, flush when cyc is low.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_vld[i]  <= 1'b0;
            r_perr[i] <= 1'b0;
            r_dat[i]  <= '0;
         end
      end else begin
         r_vld[0]  <= w_accept;
         r_perr[0] <= w_accept && !w_inwin;
         r_dat[0]  <= (w_accept && !i_wb_we && w_inwin) ? r_mem[w_idx] : '0;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i]  <= i_wb_cyc && r_vld[i-1];
            r_perr[i] <= i_wb_cyc && r_perr[i-1];
            r_dat[i]  <= r_dat[i-1];
         end
      end
   end

   // Outstanding count: a slot leaving the pipeline retires one, emitted or suppressed.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pending <= 3'd0;
      end else if (!i_wb_cyc) begin
         r_pending <= 3'd0;
      end else begin
         r_pending <= r_pending + {2'b00, w_accept} - {2'b00, w_slot_vld};
      end
   end

   // Saturating error-response counter.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_err_count <= 16'h0000;
      end else if (o_wb_err && (r_err_count != 16'hffff)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_wb_faultmem.sv
// Bench for wb_faultmem: two instances (LATENCY 1 and 3) share one stimulus
// stream; a transaction-level model predicts every output each cycle.
module tb_wb_faultmem;

   localparam int AW = 30;
   localparam logic [AW-1:0] WIN = 30'h0000_2010;  // BASE=1, 13-bit word index, offset 0x10
   localparam logic [AW-1:0] OOW = 30'h0000_4010;  // upper bits = 2

   logic        clk;
   logic        rst_n, cyc, stb, we;
   logic [AW-1:0] addr;
   logic [31:0] wdat;
   logic [3:0]  sel;
   logic [7:0]  pat;

   logic        stall_l1, ack_l1, err_l1, stall_l3, ack_l3, err_l3;
   logic [31:0] dat_l1, dat_l3;
   logic [2:0]  pend_l1, pend_l3;
   logic [15:0] ecnt_l1, ecnt_l3;

   wb_faultmem #(.DW(32), .AW(AW), .LGMEMSZ(15), .BASE(1), .LATENCY(1)) u_dut_l1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_stall(stall_l1),
      .o_wb_ack(ack_l1), .o_wb_err(err_l1), .o_wb_data(dat_l1), .i_stall_pattern(pat),
      .o_pending(pend_l1), .o_err_count(ecnt_l1));

   wb_faultmem #(.DW(32), .AW(AW), .LGMEMSZ(15), .BASE(1), .LATENCY(3)) u_dut_l3 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_stall(stall_l3),
      .o_wb_ack(ack_l3), .o_wb_err(err_l3), .o_wb_data(dat_l3), .i_stall_pattern(pat),
      .o_pending(pend_l3), .o_err_count(ecnt_l3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          k;
      int          acc;
      int          due;
      bit          err;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      bit          we;
      logic [AW-1:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } req_t;

   resp_t       q[$];
   req_t        rq[$];
   bit          fault[2];
   int          ecnt_m[2];
   logic [31:0] mem_m[2][8];
   logic [7:0]  mpat;
   int          mcnt;
   int          cyc_n;
   bit          m_acc;
   int          n_chk;
   int          n_err;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // One bus cycle: sample at negedge, compare, advance the model, return at posedge+1.
   task automatic step();
      bit          exp_stall, ea, ee, inwin;
      logic [31:0] ed;
      int          np, idx;
      bit          g_stall, g_ack, g_err;
      logic [31:0] g_dat;
      logic [2:0]  g_pend;
      logic [15:0] g_ecnt;
      string       pre;
      resp_t       r;
      resp_t       nq[$];
      @(negedge clk);
      exp_stall = cyc && rst_n && mpat[3'(mcnt % 8)];
      m_acc     = cyc && stb && !exp_stall && rst_n;
      inwin     = (addr[AW-1:13] == 17'd1);
      idx       = int'(addr[2:0]);
      for (int k = 0; k < 2; k++) begin
         ea = 0; ee = 0; ed = '0; np = 0;
         foreach (q[i]) begin
            if (q[i].k == k) begin
               if (q[i].due == cyc_n && cyc && !fault[k]) begin
                  ea = !q[i].err; ee = q[i].err; ed = q[i].data;
               end
               if (q[i].acc < cyc_n && q[i].due >= cyc_n) np++;
            end
         end
         if (k == 0) begin
            g_stall = stall_l1; g_ack = ack_l1; g_err = err_l1;
            g_dat = dat_l1; g_pend = pend_l1; g_ecnt = ecnt_l1; pre = "L1";
         end else begin
            g_stall = stall_l3; g_ack = ack_l3; g_err = err_l3;
            g_dat = dat_l3; g_pend = pend_l3; g_ecnt = ecnt_l3; pre = "L3";
         end
         check_val({pre, " stall"}, g_stall, exp_stall);
         check_val({pre, " ack"}, g_ack, ea);
         check_val({pre, " err"}, g_err, ee);
         check_val({pre, " pending"}, g_pend, np);
         check_val({pre, " err_count"}, g_ecnt, ecnt_m[k]);
         if (ea) check_val({pre, " rdata"}, g_dat, ed);
         if (ee) begin
            fault[k] = 1;
            if (ecnt_m[k] < 65535) ecnt_m[k]++;
         end
         if (m_acc) begin
            if (we && inwin && !fault[k]) begin
               for (int b = 0; b < 4; b++) begin
                  if (sel[b]) mem_m[k][idx][8*b +: 8] = wdat[8*b +: 8];
               end
            end
            r.k = k; r.acc = cyc_n; r.due = cyc_n + lat_of(k); r.err = !inwin;
            r.data = (!we && inwin) ? mem_m[k][idx] : 32'h0;
            q.push_back(r);
         end
         if (!cyc) fault[k] = 0;
      end
      foreach (q[i]) if (cyc && q[i].due > cyc_n) nq.push_back(q[i]);
      q = nq;
      if (!rst_n) begin
         mpat = 8'h00; mcnt = 0;
      end else if (!cyc) begin
         mpat = pat; mcnt = 0;
      end else begin
         mcnt++;
      end
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic add_req(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      req_t t;
      t.we = w; t.addr = a; t.data = d; t.sel = s;
      rq.push_back(t);
   endtask

   // Issue every queued request back-to-back, hold cyc for 'hold' idle cycles, then drop it.
   task automatic run_burst(input int hold);
      int budget;
      budget = 0;
      cyc = 0; stb = 0;
      step();
      cyc = 1;
      while (rq.size() > 0 && budget < 200) begin
         stb = 1; we = rq[0].we; addr = rq[0].addr; wdat = rq[0].data; sel = rq[0].sel;
         step();
         if (m_acc) rq.delete(0);
         budget++;
      end
      check_val("burst_drained", rq.size(), 0);
      rq.delete();
      stb = 0; we = 0;
      for (int i = 0; i < hold; i++) step();
      cyc = 0;
      step();
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_err = 0; cyc_n = 0; mcnt = 0; mpat = 8'h00;
      rst_n = 0; cyc = 0; stb = 0; we = 0; addr = WIN; wdat = 0; sel = 0; pat = 8'h00;
      for (int k = 0; k < 2; k++) begin
         fault[k] = 0; ecnt_m[k] = 0;
      end
      @(posedge clk); #1;
      step(); step();
      rst_n = 1;
      step();

      // Prefill the eight test words in both memories.
      for (int i = 0; i < 8; i++) add_req(1, WIN + AW'(i), $urandom, 4'hf);
      run_burst(4);

      // Full-word write then read back.
      add_req(1, WIN, 32'hDEADBEEF, 4'hf);
      add_req(0, WIN, 32'h0, 4'hf);
      run_burst(4);

      // Single byte lane over an existing word.
      add_req(1, WIN + 30'd1, 32'h11223344, 4'hf);
      add_req(1, WIN + 30'd1, 32'h0000AB00, 4'b0010);
      add_req(0, WIN + 30'd1, 32'h0, 4'hf);
      run_burst(4);

      // Four back-to-back reads.
      for (int i = 0; i < 4; i++) add_req(0, WIN + AW'(i), 32'h0, 4'hf);
      run_burst(5);

      // Stall pattern on cycles 1 and 3 of the burst.
      pat = 8'b0000_0101;
      for (int i = 0; i < 6; i++) add_req(i[0], WIN + AW'(i), $urandom, 4'hf);
      run_burst(5);
      pat = 8'h00;

      // Good read, out-of-window read, write: one ack, one err, then silence.
      add_req(0, WIN, 32'h0, 4'hf);
      add_req(0, OOW, 32'h0, 4'hf);
      add_req(1, WIN + 30'd2, 32'hCAFEF00D, 4'hf);
      run_burst(6);
      check_val("L1 err_count after fault", ecnt_l1, 16'd1);
      check_val("L3 err_count after fault", ecnt_l3, 16'd1);
      add_req(0, WIN + 30'd2, 32'h0, 4'hf);
      add_req(0, WIN, 32'h0, 4'hf);
      run_burst(5);

      // Reset asserted with requests in flight.
      cyc = 0; stb = 0;
      step();
      cyc = 1; stb = 1; we = 0; addr = WIN + 30'd3;
      step(); step();
      rst_n = 0;
      #1;
      check_val("reset ack L1", ack_l1, 1'b0);
      check_val("reset ack L3", ack_l3, 1'b0);
      check_val("reset pending L1", pend_l1, 3'd0);
      check_val("reset pending L3", pend_l3, 3'd0);
      check_val("reset stall L1", stall_l1, 1'b0);
      check_val("reset stall L3", stall_l3, 1'b0);
      check_val("reset err_count L1", ecnt_l1, 16'd0);
      q.delete();
      for (int k = 0; k < 2; k++) begin
         fault[k] = 0; ecnt_m[k] = 0;
      end
      mpat = 8'h00; mcnt = 0;
      cyc = 0; stb = 0;
      step(); step();
      rst_n = 1;
      for (int i = 0; i < 4; i++) step();

      // Randomised bursts: mixed reads/writes, out-of-window hits, random stall patterns.
      for (int n = 0; n < 60; n++) begin
         int len;
         pat = 8'($urandom_range(0, 254));
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 4) == 0) ? OOW : WIN;
            a = a + AW'($urandom_range(0, 7));
            add_req($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
         end
         run_burst($urandom_range(0, 5));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_faultmem.md
# wb_faultmem

Parametrised pipelined-Wishbone memory model with built-in fault injection, used as the downstream memory in MMU and bus-master test harnesses. It generalises the harness memory plus bus-error logic: configurable data width, depth, window base and ack latency, plus deterministic stall-pattern injection. Out-of-window requests raise a bus error and terminate the cycle. Per-cycle statistics outputs let a bench check the master's behaviour directly.

## Interface
- DW, 32: data width in bits; power of two, 8..128.
- AW, 30: word-address width of the bus.
- LGMEMSZ, 15: log2 of memory size in bytes; window holds 2^(LGMEMSZ-log2(DW/8)) words.
- BASE, 1: window index; a word address is in-window iff addr[AW-1:MW] == BASE, where MW = LGMEMSZ-log2(DW/8).
- LATENCY, 1: accept-to-ack latency in cycles, 1..4.
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  pipelined Wishbone request.
- i_wb_addr  in  AW  word address.
- i_wb_data  in  DW  write data.
- i_wb_sel  in  DW/8  byte enables.
- o_wb_stall, o_wb_ack, o_wb_err  out  1 each  slave responses.
- o_wb_data  out  DW  read data, valid with o_wb_ack.
- i_stall_pattern  in  8  stall pattern, sampled while i_wb_cyc is low.
- o_pending  out  3  accepted requests awaiting ack.
- o_err_count  out  16  saturating count of error responses.

## Operation
- Accept = i_wb_cyc && i_wb_stb && !o_wb_stall.
- Stall: 8-bit register r_pat. While !i_wb_cyc, r_pat <= i_stall_pattern. While i_wb_cyc, it rotates right one bit per cycle. o_wb_stall = i_wb_cyc && r_pat[0]. A pattern of 0 never stalls; 8'hff stalls forever.
- In-window write on accept: each byte lane with sel set is written at the accept edge. Out-of-window writes never modify memory.
- Read on accept: the word is captured at the accept edge. A read accepted the cycle after a write to the same address returns the new data.
- Response pipeline: LATENCY-stage shift of {valid, err, data}. Stage output drives o_wb_ack/o_wb_err/o_wb_data the following cycle.
- Out-of-window accept: the request carries err=1. It emerges as o_wb_err=1 with o_wb_ack=0 in the slot its ack would have occupied.
- Error state, entered when o_wb_err asserts:
  - all later responses are suppressed (no ack, no err) until i_wb_cyc falls;
  - requests are still accepted, but writes are discarded in the error state.
- Error state exits, and all pipeline stages flush, on any cycle with !i_wb_cyc. Responses never assert while i_wb_cyc is low.
- o_pending: +1 per accept, −1 per ack or err emerging. Cleared on flush. Maximum LATENCY, so it fits in 3 bits.
- o_err_count increments once per o_wb_err pulse and saturates at 16'hffff.
- States: IDLE (!cyc), ACTIVE (cyc, no error), FAULT (cyc, error seen). IDLE→ACTIVE on cyc. ACTIVE→FAULT on o_wb_err. ACTIVE/FAULT→IDLE on !cyc.

## Timing
- Reset (async assert, sync release): o_wb_ack=0, o_wb_err=0, o_wb_data=0, r_pat=0 (so o_wb_stall=0), o_pending=0, o_err_count=0, state IDLE. Memory contents are not reset.
- Accept at edge N → o_wb_ack (or o_wb_err) high during cycle N+LATENCY.
- Throughput: one request per unstalled cycle, back-to-back.
- Simultaneous accept and ack in one cycle: o_pending is unchanged.
- An error emerging in the same cycle as a later request's accept: the later request is accepted but never acknowledged.
- cyc dropped with requests outstanding: responses due that cycle or later are dropped, and o_pending=0 the next cycle.
- Reset asserted mid-burst: all outputs return to reset values immediately.

## Test plan
- LATENCY=1, pattern 0: write 0xDEADBEEF to word {BASE,0x10} with sel 4'hf, then read it back → ack one cycle after each accept, read data 0xDEADBEEF, o_pending peaks at 1.
- Byte-lane write with sel=4'b0010, data 0x0000AB00, over 0x11223344 → read returns 0x1122AB44.
- LATENCY=3, four back-to-back reads → four acks on consecutive cycles starting 3 cycles after the first accept; o_pending reaches 3.
- Pattern 8'b0000_0101 loaded, then a 6-request burst → stall high on the 1st and 3rd cycles after cyc rises, all 6 requests acked in order.
- Burst of in-window read, out-of-window read (addr upper bits ≠ BASE), in-window write → one ack, then one err, no third response, write not performed, o_err_count=1. Drop cyc, start a new burst → it is acked normally.
- Assert i_reset_n=0 with 2 requests pending → o_wb_ack, o_pending and o_wb_stall are 0 immediately; nothing is acked after release.
